// File: rtl/tetris_pkg.sv
// Shared grid geometry, edge masks and controller state encoding for the piece stepper.
package tetris_pkg;

  localparam int GRID_W = 12;
  localparam int GRID_H = 12;
  localparam int CELLS  = 144;

  function automatic logic [CELLS-1:0] col_mask(input int col);
    logic [CELLS-1:0] m;
    m = {CELLS{1'b0}};
    for (int r = 0; r < GRID_H; r++) begin
      m[r*GRID_W + col] = 1'b1;
    end
    return m;
  endfunction

  localparam logic [CELLS-1:0] COL0_MASK  = col_mask(0);
  localparam logic [CELLS-1:0] COL11_MASK = col_mask(GRID_W - 1);
  localparam logic [CELLS-1:0] ROW11_MASK = {{GRID_W{1'b1}}, {(CELLS-GRID_W){1'b0}}};

  typedef enum logic [2:0] {
    SPAWN = 3'd0,
    PLAY  = 3'd1,
    LOCK  = 3'd2,
    CLEAR = 3'd3,
    OVER  = 3'd4
  } state_t;

endpackage

// File: rtl/grid_fit_check.sv
// A candidate placement fits when the source piece touches no blocking edge
// and the moved mask overlaps nothing already settled on the board.
module grid_fit_check
  import tetris_pkg::*;
(
  input  logic [CELLS-1:0] piece,
  input  logic [CELLS-1:0] edge_mask,
  input  logic [CELLS-1:0] cand,
  input  logic [CELLS-1:0] back,
  output logic             fits
);

  assign fits = ((piece & edge_mask) == {CELLS{1'b0}}) &&
                ((cand & back) == {CELLS{1'b0}});

endmodule

// File: rtl/piece_stepper.sv
// Falling-piece controller: spawn, gravity/move/rotate, lock and row clearing.
// Define LINE_CLEAR_EN to build the CLEAR phase and the lines_cleared counter.
module piece_stepper
  import tetris_pkg::*;
#(
  parameter int GRAV_TICKS = 50
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [CELLS-1:0] spawn_sqs,
  input  logic [9:0]       spawn_center,
  input  logic             spawn_vld,
  input  logic             mv_left,
  input  logic             mv_right,
  input  logic             rot_req,
  input  logic             soft_drop,
  input  logic [CELLS-1:0] rot_sqs,
  input  logic             rot_ok,
  output logic [CELLS-1:0] currentSqs,
  output logic [9:0]       centralPoint,
  output logic [CELLS-1:0] backGround,
  output logic             spawn_req,
  output logic             game_over,
  output logic             busy,
  output logic [7:0]       lines_cleared
);

  localparam int            CW        = $clog2(GRAV_TICKS);
  localparam logic [CW-1:0] GRAV_LAST = CW'(GRAV_TICKS - 1);

  state_t           state, state_nxt;
  logic [CW-1:0]    grav_cnt, grav_cnt_nxt;
  logic [CELLS-1:0] cur_nxt, bg_nxt, down_cand, left_cand, right_cand;
  logic [9:0]       cp_nxt;
  logic             fit_down, fit_left, fit_right, grav_tick;

  assign down_cand  = currentSqs << GRID_W;
  assign left_cand  = currentSqs >> 1;
  assign right_cand = currentSqs << 1;
  // Soft drop turns every cycle into a gravity tick and restarts the count.
  assign grav_tick  = soft_drop || (grav_cnt == GRAV_LAST);

  grid_fit_check u_fit_down  (.piece(currentSqs), .edge_mask(ROW11_MASK), .cand(down_cand),
                              .back(backGround), .fits(fit_down));
  grid_fit_check u_fit_left  (.piece(currentSqs), .edge_mask(COL0_MASK),  .cand(left_cand),
                              .back(backGround), .fits(fit_left));
  grid_fit_check u_fit_right (.piece(currentSqs), .edge_mask(COL11_MASK), .cand(right_cand),
                              .back(backGround), .fits(fit_right));

`ifdef LINE_CLEAR_EN
  logic [3:0]       row_ptr, row_ptr_nxt;
  logic [7:0]       lines_nxt, row_base;
  logic             row_full;
  logic [CELLS-1:0] collapsed;

  assign row_base  = {4'd0, row_ptr} * 8'd12;
  assign row_full  = &backGround[row_base +: GRID_W];
  // Rows above the full row move down one; the full row disappears.
  assign collapsed = (backGround & ({CELLS{1'b1}} << (row_base + 8'd12))) |
                     ((backGround & ~({CELLS{1'b1}} << row_base)) << GRID_W);
`else
  assign lines_cleared = 8'd0;
`endif

  // Next-state and datapath update for the current phase.
  always_comb begin
    state_nxt    = state;
    cur_nxt      = currentSqs;
    cp_nxt       = centralPoint;
    bg_nxt       = backGround;
    grav_cnt_nxt = grav_cnt;
`ifdef LINE_CLEAR_EN
    row_ptr_nxt  = row_ptr;
    lines_nxt    = lines_cleared;
`endif
    case (state)
      SPAWN: begin
        if (spawn_vld) begin
          if ((spawn_sqs & backGround) != {CELLS{1'b0}}) begin
            state_nxt = OVER;
          end else begin
            cur_nxt      = spawn_sqs;
            cp_nxt       = spawn_center;
            grav_cnt_nxt = {CW{1'b0}};
            state_nxt    = PLAY;
          end
        end else begin
          state_nxt = SPAWN;
        end
      end
      PLAY: begin
        if (grav_tick) begin
          grav_cnt_nxt = {CW{1'b0}};
          if (fit_down) begin
            cur_nxt = down_cand;
            cp_nxt  = centralPoint + 10'd12;
          end else begin
            state_nxt = LOCK;
          end
        end else begin
          grav_cnt_nxt = grav_cnt + CW'(1);
          if (rot_req) begin
            cur_nxt = rot_ok ? rot_sqs : currentSqs;
          end else if (mv_left) begin
            if (fit_left) begin
              cur_nxt = left_cand;
              cp_nxt  = centralPoint - 10'd1;
            end else begin
              cur_nxt = currentSqs;
            end
          end else if (mv_right) begin
            if (fit_right) begin
              cur_nxt = right_cand;
              cp_nxt  = centralPoint + 10'd1;
            end else begin
              cur_nxt = currentSqs;
            end
          end else begin
            cur_nxt = currentSqs;
          end
        end
      end
      LOCK: begin
        bg_nxt  = backGround | currentSqs;
        cur_nxt = {CELLS{1'b0}};
`ifdef LINE_CLEAR_EN
        row_ptr_nxt = 4'd11;
        state_nxt   = CLEAR;
`else
        state_nxt   = SPAWN;
`endif
      end
`ifdef LINE_CLEAR_EN
      CLEAR: begin
        if (row_full) begin
          bg_nxt    = collapsed;
          lines_nxt = (lines_cleared == 8'hFF) ? 8'hFF : lines_cleared + 8'd1;
        end else if (row_ptr == 4'd0) begin
          state_nxt = SPAWN;
        end else begin
          row_ptr_nxt = row_ptr - 4'd1;
        end
      end
`endif
      OVER:    state_nxt = OVER;
      default: state_nxt = SPAWN;
    endcase
  end

  // Phase register plus the status flags decoded from the upcoming phase.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= SPAWN;
      spawn_req <= 1'b1;
      game_over <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      spawn_req <= (state_nxt == SPAWN);
      game_over <= (state_nxt == OVER);
      busy      <= (state_nxt == LOCK) || (state_nxt == CLEAR);
    end
  end

  // Piece, board and gravity counter registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      currentSqs   <= {CELLS{1'b0}};
      centralPoint <= 10'd0;
      backGround   <= {CELLS{1'b0}};
      grav_cnt     <= {CW{1'b0}};
    end else begin
      currentSqs   <= cur_nxt;
      centralPoint <= cp_nxt;
      backGround   <= bg_nxt;
      grav_cnt     <= grav_cnt_nxt;
    end
  end

`ifdef LINE_CLEAR_EN
  // Row scan pointer and cleared-line tally.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      row_ptr       <= 4'd11;
      lines_cleared <= 8'd0;
    end else begin
      row_ptr       <= row_ptr_nxt;
      lines_cleared <= lines_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_piece_stepper.sv
// Self-checking bench for piece_stepper: directed scenarios plus random play,
// compared every cycle against a cell-coordinate reference model.
module tb_piece_stepper;

  localparam int G = 4;
  typedef enum int {P_SPAWN, P_PLAY, P_LOCK, P_CLEAR, P_OVER} ph_t;

  logic         clock = 1'b0;
  logic         resetn;
  logic [143:0] spawn_sqs, rot_sqs, currentSqs, backGround;
  logic [9:0]   spawn_center, centralPoint;
  logic         spawn_vld, mv_left, mv_right, rot_req, rot_ok, soft_drop;
  logic         spawn_req, game_over, busy;
  logic [7:0]   lines_cleared;

  int n_cmp = 0;
  int n_bad = 0;

  ph_t          m_phase;
  logic [143:0] m_cur, m_bg, m_pend_bg;
  logic [9:0]   m_cp;
  int           m_lines, m_cnt, m_clear_left, m_pend_k;

  int shape_cells [7][4] = '{'{0,1,12,13}, '{0,1,2,3}, '{0,1,2,13}, '{1,2,12,13},
                             '{0,1,13,14}, '{0,1,2,12}, '{0,1,2,14}};

  piece_stepper #(.GRAV_TICKS(G)) dut (
    .clock(clock), .resetn(resetn), .spawn_sqs(spawn_sqs), .spawn_center(spawn_center),
    .spawn_vld(spawn_vld), .mv_left(mv_left), .mv_right(mv_right), .rot_req(rot_req),
    .soft_drop(soft_drop), .rot_sqs(rot_sqs), .rot_ok(rot_ok), .currentSqs(currentSqs),
    .centralPoint(centralPoint), .backGround(backGround), .spawn_req(spawn_req),
    .game_over(game_over), .busy(busy), .lines_cleared(lines_cleared));

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [143:0] cells4(input int a, input int b, input int c, input int d);
    logic [143:0] m;
    m = '0; m[a] = 1'b1; m[b] = 1'b1; m[c] = 1'b1; m[d] = 1'b1;
    return m;
  endfunction

  // Move every occupied cell by (dr, dc); illegal if any leaves the grid or hits the board.
  task automatic try_shift(input logic [143:0] m, input logic [143:0] bg, input int dr,
                           input int dc, output logic ok, output logic [143:0] nm);
    ok = 1'b1; nm = '0;
    for (int i = 0; i < 144; i++) begin
      if (m[i]) begin
        int nr, nc;
        nr = i / 12 + dr; nc = i % 12 + dc;
        if (nr < 0 || nr > 11 || nc < 0 || nc > 11) ok = 1'b0;
        else begin
          if (bg[nr*12+nc]) ok = 1'b0;
          nm[nr*12+nc] = 1'b1;
        end
      end
    end
  endtask

  // Final board after removing every full row and letting the rest settle in order.
  task automatic compact(input logic [143:0] bg, output logic [143:0] nb, output int k);
    int dst;
    nb = '0; k = 0; dst = 11;
    for (int r = 11; r >= 0; r--) begin
      bit full;
      full = 1'b1;
      for (int c = 0; c < 12; c++) if (!bg[r*12+c]) full = 1'b0;
      if (full) k++;
      else begin
        for (int c = 0; c < 12; c++) nb[dst*12+c] = bg[r*12+c];
        dst--;
      end
    end
  endtask

  task automatic model_reset();
    m_phase = P_SPAWN; m_cur = '0; m_bg = '0; m_cp = '0;
    m_lines = 0; m_cnt = 0; m_clear_left = 0; m_pend_k = 0; m_pend_bg = '0;
  endtask

  task automatic model_step();
    logic ok, tick;
    logic [143:0] nm;
    case (m_phase)
      P_SPAWN: if (spawn_vld) begin
        if ((spawn_sqs & m_bg) != '0) m_phase = P_OVER;
        else begin
          m_cur = spawn_sqs; m_cp = spawn_center; m_cnt = 0; m_phase = P_PLAY;
        end
      end
      P_PLAY: begin
        tick  = soft_drop || (m_cnt == G - 1);
        m_cnt = tick ? 0 : m_cnt + 1;
        if (tick) begin
          try_shift(m_cur, m_bg, 1, 0, ok, nm);
          if (ok) begin m_cur = nm; m_cp = m_cp + 10'd12; end
          else m_phase = P_LOCK;
        end else if (rot_req) begin
          if (rot_ok) m_cur = rot_sqs;
        end else if (mv_left) begin
          try_shift(m_cur, m_bg, 0, -1, ok, nm);
          if (ok) begin m_cur = nm; m_cp = m_cp - 10'd1; end
        end else if (mv_right) begin
          try_shift(m_cur, m_bg, 0, 1, ok, nm);
          if (ok) begin m_cur = nm; m_cp = m_cp + 10'd1; end
        end
      end
      P_LOCK: begin
        m_bg  = m_bg | m_cur;
        m_cur = '0;
`ifdef LINE_CLEAR_EN
        compact(m_bg, m_pend_bg, m_pend_k);
        m_clear_left = 12 + m_pend_k;
        m_phase = P_CLEAR;
`else
        m_phase = P_SPAWN;
`endif
      end
      P_CLEAR: begin
        m_clear_left--;
        if (m_clear_left == 0) begin
          m_bg    = m_pend_bg;
          m_lines = (m_lines + m_pend_k > 255) ? 255 : m_lines + m_pend_k;
          m_phase = P_SPAWN;
        end
      end
      default: ;
    endcase
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".spawn_req"}, 144'(spawn_req), 144'(m_phase == P_SPAWN));
    chk({tag, ".game_over"}, 144'(game_over), 144'(m_phase == P_OVER));
    chk({tag, ".busy"}, 144'(busy), 144'(m_phase == P_LOCK || m_phase == P_CLEAR));
    chk({tag, ".currentSqs"}, currentSqs, m_cur);
    chk({tag, ".centralPoint"}, 144'(centralPoint), 144'(m_cp));
    if (m_phase != P_CLEAR) begin
      chk({tag, ".backGround"}, backGround, m_bg);
      chk({tag, ".lines_cleared"}, 144'(lines_cleared), 144'(m_lines));
    end
  endtask

  task automatic set_idle();
    spawn_sqs = '0; spawn_center = '0; spawn_vld = 1'b0; mv_left = 1'b0; mv_right = 1'b0;
    rot_req = 1'b0; rot_ok = 1'b0; rot_sqs = '0; soft_drop = 1'b0;
  endtask

  task automatic step(input string tag);
    model_step();
    @(posedge clock);
    #1;
    check_all(tag);
  endtask

  // Called 1 unit after a rising edge; reset is asserted and released between edges.
  task automatic do_reset();
    set_idle();
    resetn = 1'b0;
    model_reset();
    #2;
    check_all("reset");
    #1;
    resetn = 1'b1;
  endtask

  task automatic run_until(input ph_t target, input int budget, input string tag);
    int n;
    n = 0;
    while (m_phase != target && n < budget) begin
      step(tag);
      n++;
    end
    if (m_phase != target) begin
      n_cmp++; n_bad++;
      $error("FAIL %s: no progress after %0d cycles, wanted phase %0d", tag, n, target);
    end
  endtask

  task automatic rand_inputs();
    int p, off;
    logic ok;
    logic [143:0] nm;
    p = $urandom_range(0, 6); off = $urandom_range(0, 8);
    spawn_sqs = '0;
    for (int j = 0; j < 4; j++) spawn_sqs[shape_cells[p][j] + off] = 1'b1;
    spawn_center = 10'(off + 1);
    spawn_vld = ($urandom_range(0, 2) == 0);
    mv_left   = ($urandom_range(0, 3) == 0);
    mv_right  = ($urandom_range(0, 3) == 0);
    rot_req   = ($urandom_range(0, 3) == 0);
    soft_drop = ($urandom_range(0, 3) == 0);
    try_shift(m_cur, m_bg, 0, 1, ok, nm);
    rot_sqs = nm;
    rot_ok  = ok && ($urandom_range(0, 1) == 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [143:0] o_top, o_bot, v_dom, x_rot, x_down, pc, exp_bg, col5;

    o_top  = cells4(4, 5, 16, 17);
    o_bot  = cells4(124, 125, 136, 137);
    v_dom  = '0; v_dom[0] = 1'b1; v_dom[12] = 1'b1;
    x_rot  = '0; x_rot[1] = 1'b1; x_rot[2] = 1'b1;
    x_down = '0; x_down[13] = 1'b1; x_down[14] = 1'b1;

    set_idle();
    resetn = 1'b0;
    model_reset();
    @(posedge clock);
    #1;
    check_all("por");
    #3 resetn = 1'b1;

    // Spawn the O-piece at the top.
    spawn_sqs = o_top; spawn_center = 10'd5; spawn_vld = 1'b1;
    step("spawn");
    set_idle();
    chk("spawn_cur", currentSqs, o_top);
    chk("spawn_cp", 144'(centralPoint), 144'd5);
    chk("spawn_req_low", 144'(spawn_req), 144'd0);

    // Gravity carries it to the floor, then it locks into the board.
    run_until(P_LOCK, 100, "fall");
    chk("lock_cur", currentSqs, o_bot);
    step("lock");
    chk("lock_bg", backGround, o_bot);
    run_until(P_SPAWN, 100, "post_lock");

    // Wall-blocked left move, rotation reject/accept, gravity beating a left move.
    spawn_sqs = v_dom; spawn_center = 10'd0; spawn_vld = 1'b1;
    step("spawn2");
    set_idle();
    mv_left = 1'b1;
    step("left_wall");
    mv_left = 1'b0;
    chk("left_wall_cur", currentSqs, v_dom);
    rot_req = 1'b1; rot_ok = 1'b0; rot_sqs = x_rot;
    step("rot_reject");
    chk("rot_reject_cur", currentSqs, v_dom);
    rot_ok = 1'b1;
    step("rot_accept");
    set_idle();
    chk("rot_accept_cur", currentSqs, x_rot);
    chk("rot_accept_cp", 144'(centralPoint), 144'd0);
    mv_left = 1'b1;
    step("left_vs_grav");
    mv_left = 1'b0;
    chk("left_vs_grav_cur", currentSqs, x_down);
    chk("left_vs_grav_cp", 144'(centralPoint), 144'd12);
    run_until(P_SPAWN, 200, "drop2");

    // A piece that completes rows 10 and 11 with one extra cell above them.
    pc = '0; pc[0] = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (!m_bg[120+c]) pc[12+c] = 1'b1;
      if (!m_bg[132+c]) pc[24+c] = 1'b1;
    end
    spawn_sqs = pc; spawn_center = 10'd12; spawn_vld = 1'b1; soft_drop = 1'b1;
    step("spawn3");
    spawn_vld = 1'b0;
    run_until(P_LOCK, 50, "drop3");
    step("lock3");
    run_until(P_SPAWN, 50, "clear3");
    set_idle();
`ifdef LINE_CLEAR_EN
    exp_bg = '0; exp_bg[132] = 1'b1;
    chk("clear_lines", 144'(lines_cleared), 144'd2);
`else
    exp_bg = '0; exp_bg[108] = 1'b1;
    for (int i = 120; i < 144; i++) exp_bg[i] = 1'b1;
    chk("clear_lines", 144'(lines_cleared), 144'd0);
`endif
    chk("clear_bg", backGround, exp_bg);
    chk("clear_spawn_req", 144'(spawn_req), 144'd1);

    // Column-5 stack, then a spawn overlapping cell 5 ends the game.
    do_reset();
    col5 = '0;
    for (int r = 0; r < 12; r++) col5[r*12+5] = 1'b1;
    spawn_sqs = col5; spawn_center = 10'd65; spawn_vld = 1'b1;
    step("spawn4");
    set_idle();
    run_until(P_SPAWN, 100, "lock4");
    chk("col5_bg", backGround, col5);
    spawn_sqs = o_top; spawn_center = 10'd5; spawn_vld = 1'b1;
    step("over");
    chk("over_flag", 144'(game_over), 144'd1);
    for (int k = 0; k < 8; k++) begin
      rand_inputs();
      spawn_vld = 1'b1;
      step("over_hold");
    end
    chk("over_persist", 144'(game_over), 144'd1);
    do_reset();
    chk("over_cleared", 144'(game_over), 144'd0);

    // Random play, with resets on game over and occasionally mid-lock/mid-clear.
    for (int k = 0; k < 1500; k++) begin
      if (m_phase == P_OVER) do_reset();
      else if ((m_phase == P_LOCK || m_phase == P_CLEAR) && $urandom_range(0, 5) == 0) do_reset();
      rand_inputs();
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
